// File: rtl/wb_dest_pipe_pkg.sv
// Shared pipeline definitions: register-address width, the R0 constant,
// forwarding select codes and the packed layouts of the three stage registers.
package pipe_pkg;

    localparam int REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t ZERO_REG = 5'd0;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        reg_addr_t rs;
        reg_addr_t rt;
        reg_addr_t rd;
        logic      reg_write;
        logic      mem_read;
    } id_ex_t;

    typedef struct packed {
        reg_addr_t rd;
        logic      reg_write;
        logic      mem_read;
    } ex_mem_t;

    typedef struct packed {
        reg_addr_t rd;
        logic      reg_write;
    } mem_wb_t;

    // R0 is hard-wired, so a write aimed at it is never tracked downstream.
    function automatic logic tracked_write(input logic reg_write, input reg_addr_t rd);
        return reg_write && (rd != ZERO_REG);
    endfunction

endpackage

// File: rtl/wb_dest_pipe_if.sv
// Bundle of ID-stage inputs, hazard controls and stage-register outputs.
// The stall_cnt_o counter output exists only when WB_STALL_CNT_EN is defined.
interface wb_dest_pipe_if;

    logic [4:0]  IF_ID_RsAddr_i;
    logic [4:0]  IF_ID_RtAddr_i;
    logic        ID_RegWrite_i;
    logic        ID_MemRead_i;
    logic [4:0]  ID_RdAddr_i;
    logic        flush_i;
    logic        mem_ready_i;
    logic [4:0]  ID_EX_RsAddr_o;
    logic [4:0]  ID_EX_RtAddr_o;
    logic        EX_MEM_RegWrite_o;
    logic [4:0]  EX_MEM_RdAddr_o;
    logic        MEM_WB_RegWrite_o;
    logic [4:0]  MEM_WB_RdAddr_o;
    logic        stall_o;
    logic        freeze_o;
`ifdef WB_STALL_CNT_EN
    logic [15:0] stall_cnt_o;
`endif

    modport master (
`ifdef WB_STALL_CNT_EN
        input  stall_cnt_o,
`endif
        output IF_ID_RsAddr_i, IF_ID_RtAddr_i, ID_RegWrite_i, ID_MemRead_i,
               ID_RdAddr_i, flush_i, mem_ready_i,
        input  ID_EX_RsAddr_o, ID_EX_RtAddr_o, EX_MEM_RegWrite_o, EX_MEM_RdAddr_o,
               MEM_WB_RegWrite_o, MEM_WB_RdAddr_o, stall_o, freeze_o
    );

    modport slave (
`ifdef WB_STALL_CNT_EN
        output stall_cnt_o,
`endif
        input  IF_ID_RsAddr_i, IF_ID_RtAddr_i, ID_RegWrite_i, ID_MemRead_i,
               ID_RdAddr_i, flush_i, mem_ready_i,
        output ID_EX_RsAddr_o, ID_EX_RtAddr_o, EX_MEM_RegWrite_o, EX_MEM_RdAddr_o,
               MEM_WB_RegWrite_o, MEM_WB_RdAddr_o, stall_o, freeze_o
    );

endinterface

// File: rtl/wb_dest_pipe_load_use_detect.sv
// Combinational load-use hazard check between the load in ID/EX and the
// source registers of the instruction currently in ID.
module load_use_detect
    import pipe_pkg::*;
(
    input  logic      i_id_ex_mem_read,
    input  reg_addr_t i_id_ex_rd,
    input  reg_addr_t i_if_id_rs,
    input  reg_addr_t i_if_id_rt,
    output logic      o_load_use
);

    logic w_rd_match;

    assign w_rd_match = (i_id_ex_rd == i_if_id_rs) || (i_id_ex_rd == i_if_id_rt);
    assign o_load_use = i_id_ex_mem_read && (i_id_ex_rd != ZERO_REG) && w_rd_match;

endmodule

// File: rtl/wb_dest_pipe.sv
// Destination/source tracking registers for a 5-stage pipeline with load-use
// bubble insertion and memory-wait freeze. Optional stall counter: WB_STALL_CNT_EN.
module wb_dest_pipe
    import pipe_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_n_i,
    wb_dest_pipe_if.slave   bus
);

    id_ex_t  r_id_ex;
    ex_mem_t r_ex_mem;
    mem_wb_t r_mem_wb;

    logic    w_load_use;
    logic    w_freeze;
    logic    w_stall;
    id_ex_t  w_id_capture;

    load_use_detect u_load_use_detect (
        .i_id_ex_mem_read (r_id_ex.mem_read),
        .i_id_ex_rd       (r_id_ex.rd),
        .i_if_id_rs       (bus.IF_ID_RsAddr_i),
        .i_if_id_rt       (bus.IF_ID_RtAddr_i),
        .o_load_use       (w_load_use)
    );

    assign w_freeze = r_ex_mem.mem_read && !bus.mem_ready_i;
    assign w_stall  = w_freeze || w_load_use;

    always_comb begin
        w_id_capture.rs        = bus.IF_ID_RsAddr_i;
        w_id_capture.rt        = bus.IF_ID_RtAddr_i;
        w_id_capture.rd        = bus.ID_RdAddr_i;
        w_id_capture.reg_write = tracked_write(bus.ID_RegWrite_i, bus.ID_RdAddr_i);
        w_id_capture.mem_read  = bus.ID_MemRead_i;
    end

    // Freeze outranks everything; a flush or load-use only replaces the ID/EX entry.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_id_ex  <= '0;
            r_ex_mem <= '0;
            r_mem_wb <= '0;
        end else if (!w_freeze) begin
            if (bus.flush_i || w_load_use) begin
                r_id_ex <= '0;
            end else begin
                r_id_ex <= w_id_capture;
            end
            r_ex_mem.rd        <= r_id_ex.rd;
            r_ex_mem.reg_write <= tracked_write(r_id_ex.reg_write, r_id_ex.rd);
            r_ex_mem.mem_read  <= r_id_ex.mem_read;
            r_mem_wb.rd        <= r_ex_mem.rd;
            r_mem_wb.reg_write <= tracked_write(r_ex_mem.reg_write, r_ex_mem.rd);
        end
    end

`ifdef WB_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_stall_cnt <= 16'd0;
        end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign bus.stall_cnt_o = r_stall_cnt;
`endif

    assign bus.ID_EX_RsAddr_o    = r_id_ex.rs;
    assign bus.ID_EX_RtAddr_o    = r_id_ex.rt;
    assign bus.EX_MEM_RegWrite_o = r_ex_mem.reg_write;
    assign bus.EX_MEM_RdAddr_o   = r_ex_mem.rd;
    assign bus.MEM_WB_RegWrite_o = r_mem_wb.reg_write;
    assign bus.MEM_WB_RdAddr_o   = r_mem_wb.rd;
    assign bus.stall_o           = w_stall;
    assign bus.freeze_o          = w_freeze;

endmodule

// File: doc/wb_dest_pipe.md
WB_DEST_PIPE -- requirements
Module: wb_dest_pipe

Interface
REQ-001 SHALL have port clk_i, input, 1, sole clock, rising edge.
REQ-002 SHALL have port rst_n_i, input, 1, reset, asynchronous, active-low.
REQ-003 SHALL have ports IF_ID_RsAddr_i / IF_ID_RtAddr_i, input, 5 each, source registers of the instruction in ID.
REQ-004 SHALL have ports ID_RegWrite_i, ID_MemRead_i (input, 1) and ID_RdAddr_i (input, 5), decoded destination info of the ID instruction.
REQ-005 SHALL have port flush_i, input, 1, branch taken: discard the ID instruction.
REQ-006 SHALL have port mem_ready_i, input, 1, data memory has completed the MEM-stage load.
REQ-007 SHALL have ports ID_EX_RsAddr_o / ID_EX_RtAddr_o, output, 5 each, EX-stage source registers.
REQ-008 SHALL have ports EX_MEM_RegWrite_o (1) / EX_MEM_RdAddr_o (5), output, MEM-stage pending write.
REQ-009 SHALL have ports MEM_WB_RegWrite_o (1) / MEM_WB_RdAddr_o (5), output, WB-stage pending write.
REQ-010 SHALL have port stall_o, output, 1, hold PC and IF/ID this cycle.
REQ-011 SHALL have port freeze_o, output, 1, hold every pipeline register this cycle.

Function
REQ-012 SHALL hold three stage registers: ID/EX {Rs, Rt, Rd, RegWrite, MemRead}, EX/MEM {Rd, RegWrite, MemRead}, MEM/WB {Rd, RegWrite}, all outputs driven directly from these flops.
REQ-013 SHALL capture RegWrite as 0 whenever the captured Rd is 5'd0 (writes to R0 never tracked).
REQ-014 SHALL assert load_use combinationally when ID/EX MemRead=1, ID/EX Rd!=0, and ID/EX Rd equals IF_ID_RsAddr_i or IF_ID_RtAddr_i.
REQ-015 SHALL assert freeze_o combinationally when EX/MEM MemRead=1 and mem_ready_i=0.
REQ-016 SHALL drive stall_o = freeze_o OR load_use.
REQ-017 SHALL, per edge, apply first matching rule: freeze -> all three stages hold; else flush_i or load_use -> ID/EX loads bubble (all fields 0), EX/MEM<=ID/EX, MEM/WB<=EX/MEM; else normal advance ID->ID/EX->EX/MEM->MEM/WB.
REQ-018 SHALL produce exactly one bubble per load-use hazard: next cycle ID/EX MemRead=0 so load_use deasserts and the held ID instruction advances.
REQ-019 SHALL, with flush_i and load_use simultaneous, insert one bubble only (flush wins, no extra stall effect on ID/EX).
REQ-020 SHALL, with freeze lasting N cycles, keep all outputs constant for N cycles and resume normal advance on the first edge with mem_ready_i=1.
REQ-021 SHALL have latency of exactly one cycle per stage: ID values visible on ID_EX_* after 1 edge, EX_MEM_* after 2, MEM_WB_* after 3 (no stalls).

Reset
REQ-022 SHALL, while rst_n_i=0, force all stage registers to 0 asynchronously (all addr outputs 5'd0, RegWrite/MemRead 0).
REQ-023 SHALL, with stage registers at 0, present stall_o=0 and freeze_o=0 during and after reset.
REQ-024 SHALL, on reset asserted mid-freeze or mid-stall, discard all in-flight entries; first post-reset edge is a normal advance.

Configuration
REQ-025 SHALL, with WB_STALL_CNT_EN defined, add output stall_cnt_o (16 bits) counting cycles with stall_o=1, saturating at 16'hFFFF, reset to 0.
REQ-026 SHALL, without WB_STALL_CNT_EN, omit stall_cnt_o and its counter entirely.

Structure
REQ-027 SHALL take from shared package pipe_pkg: ZERO_REG (5'd0), REG_ADDR_W (5), forwarding select codes FWD_NONE 2'b00, FWD_WB 2'b01, FWD_MEM 2'b10.
REQ-028 SHALL place REQ-014 logic in sub-module load_use_detect (purely combinational); stage registers stay in wb_dest_pipe.

Verification
REQ-029 SHALL cover: ID add Rd=3 RegWrite=1 -> EX_MEM_RdAddr_o=3, RegWrite=1 after 2 edges; MEM_WB_RdAddr_o=3 after 3.
REQ-030 SHALL cover: lw Rd=5 then ID Rs=5 -> stall_o=1 one cycle, ID/EX bubble (RegWrite=0), dependent instruction in ID/EX one edge later.
REQ-031 SHALL cover: lw in EX/MEM, mem_ready_i=0 for 3 cycles -> freeze_o=1, outputs constant 3 cycles, advance on 4th.
REQ-032 SHALL cover: ID RegWrite=1 Rd=0 -> EX_MEM_RegWrite_o=0 at stage; lw Rd=0 followed by Rs=0 -> no stall.
REQ-033 SHALL cover: flush_i=1 coincident with load_use -> single bubble, stall_o=1 one cycle.
REQ-034 SHALL cover: rst_n_i low mid-freeze -> all outputs 0 immediately (asynchronous), stall_cnt_o=0 when WB_STALL_CNT_EN defined.
